// File: rtl/sd_sector_streamer.sv
// sd_sector_streamer: fetches a run of consecutive SD sectors and streams the words through a FWFT FIFO
// Ports: clk/rst_n (async active-low); i_cfg_* run control (start, abort, base, count);
//   o_rstart/o_rsector/i_rbusy/i_rdone/i_rd_data/i_rd_data_en sector reader handshake;
//   o_m_valid/i_m_ready/o_m_data/o_m_last consumer stream; o_busy/o_done/o_err_overflow/o_err_short/o_fifo_level status.
module sd_sector_streamer #(
  parameter int FIFO_AW      = 10,
  parameter int SECTOR_WORDS = 256,
  parameter bit SWAP_BYTES   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_cfg_start,
  input  logic               i_cfg_abort,
  input  logic [31:0]        i_cfg_sector_base,
  input  logic [31:0]        i_cfg_sector_count,
  output logic               o_rstart,
  output logic [31:0]        o_rsector,
  input  logic               i_rbusy,
  input  logic               i_rdone,
  input  logic [15:0]        i_rd_data,
  input  logic               i_rd_data_en,
  output logic               o_m_valid,
  input  logic               i_m_ready,
  output logic [15:0]        o_m_data,
  output logic               o_m_last,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err_overflow,
  output logic               o_err_short,
  output logic [FIFO_AW:0]   o_fifo_level
);
  localparam logic [FIFO_AW:0] LP_DEPTH = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] LP_SW    = (FIFO_AW+1)'(SECTOR_WORDS);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_XFER, S_DRAIN} state_t;
  state_t r_state, w_next;
  logic [31:0] r_cur_sec, r_remaining, r_wcnt, r_out_cnt, r_last_idx;
  logic [15:0] r_mem [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0] r_level;
  logic r_rstart, r_done, r_err_ovf, r_err_short;
  logic [31:0] r_rsector;
  logic w_start, w_xfer_push, w_full, w_pop, w_push, w_room;
  logic [31:0] w_wcnt_fin;
  logic [15:0] w_word;
  assign w_start     = i_cfg_start && !i_cfg_abort && r_state == S_IDLE;
  assign w_xfer_push = i_rd_data_en && r_state == S_XFER;
  assign w_full      = r_level == LP_DEPTH;
  assign w_pop       = o_m_valid && i_m_ready;
  // a pop in the same cycle frees the slot the incoming word needs
  assign w_push      = w_xfer_push && (!w_full || w_pop);
  assign w_room      = (LP_DEPTH - r_level) >= LP_SW;
  assign w_wcnt_fin  = r_wcnt + {31'd0, i_rd_data_en};
  assign w_word      = SWAP_BYTES ? {i_rd_data[7:0], i_rd_data[15:8]} : i_rd_data;
  always_comb begin
    w_next = r_state;
    if (i_cfg_abort) w_next = S_IDLE;
    else case (r_state)
      S_IDLE:  if (i_cfg_start && i_cfg_sector_count != 32'd0) w_next = S_WAIT;
      S_WAIT:  if (!i_rbusy && w_room) w_next = S_REQ;
      S_REQ:   if (i_rbusy) w_next = S_XFER;
      S_XFER:  if (i_rdone) w_next = (r_remaining == 32'd1) ? S_DRAIN : S_WAIT;
      S_DRAIN: if (r_level == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstart    <= 1'b0;
      r_rsector   <= '0;
      r_done      <= 1'b0;
      r_cur_sec   <= '0;
      r_remaining <= '0;
      r_wcnt      <= '0;
      r_out_cnt   <= '0;
      r_last_idx  <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_err_ovf   <= 1'b0;
      r_err_short <= 1'b0;
    end else begin
      r_rstart <= w_next == S_REQ;
      if (r_state == S_WAIT) r_rsector <= r_cur_sec;
      r_done <= (r_state == S_DRAIN && r_level == '0 && !i_cfg_abort) ||
                (w_start && i_cfg_sector_count == 32'd0);
      // count restarts while the request is outstanding, so it is zero on XFER entry
      if (r_state == S_REQ) r_wcnt <= '0;
      else if (w_xfer_push) r_wcnt <= r_wcnt + 32'd1;
      if (r_state == S_XFER && i_rdone) begin
        r_cur_sec   <= r_cur_sec + 32'd1;
        r_remaining <= r_remaining - 32'd1;
        if (w_wcnt_fin != 32'(SECTOR_WORDS)) r_err_short <= 1'b1;
      end
      if (i_cfg_abort) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop) r_rptr <= r_rptr + 1'b1;
        if (w_pop) r_out_cnt <= r_out_cnt + 32'd1;
        r_level <= r_level + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};
        if (w_xfer_push && w_full && !w_pop) r_err_ovf <= 1'b1;
      end
      if (w_start) begin
        r_cur_sec   <= i_cfg_sector_base;
        r_remaining <= i_cfg_sector_count;
        r_out_cnt   <= '0;
        r_last_idx  <= i_cfg_sector_count * 32'(SECTOR_WORDS) - 32'd1;
        r_err_ovf   <= 1'b0;
        r_err_short <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wptr] <= w_word;
  assign o_m_valid      = r_level != '0;
  assign o_m_data       = o_m_valid ? r_mem[r_rptr] : 16'd0;
  assign o_m_last       = o_m_valid && r_out_cnt == r_last_idx;
  assign o_rstart       = r_rstart;
  assign o_rsector      = r_rsector;
  assign o_busy         = r_state != S_IDLE;
  assign o_done         = r_done;
  assign o_err_overflow = r_err_ovf;
  assign o_err_short    = r_err_short;
  assign o_fifo_level   = r_level;
endmodule

// File: tb/tb_sd_sector_streamer.sv
// tb_sd_sector_streamer: randomized reader/consumer bench with a queue-based reference model
module tb_sd_sector_streamer;
  localparam int AW = 9;
  localparam int SW = 256;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_cfg_start = 1'b0, i_cfg_abort = 1'b0;
  logic [31:0] i_cfg_sector_base = '0, i_cfg_sector_count = '0;
  logic o_rstart, i_rbusy, i_rdone = 1'b0, i_rd_data_en = 1'b0;
  logic [31:0] o_rsector;
  logic [15:0] i_rd_data = '0, o_m_data;
  logic o_m_valid, i_m_ready = 1'b0, o_m_last, o_busy, o_done, o_err_overflow, o_err_short;
  logic [AW:0] o_fifo_level;
  logic rd_busy = 1'b0, hold_busy = 1'b0, model_en = 1'b0, short_once = 1'b0;
  int n_cmp = 0, n_err = 0, done_cnt = 0, last_cnt = 0;
  int unsigned pop_idx = 0, run_words = 0;
  logic [15:0] exp_q[$];
  logic [31:0] sec_q[$];
  assign i_rbusy = rd_busy | hold_busy;
  always #5 clk = ~clk;
  sd_sector_streamer #(.FIFO_AW(AW), .SECTOR_WORDS(SW), .SWAP_BYTES(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_cfg_start(i_cfg_start), .i_cfg_abort(i_cfg_abort),
    .i_cfg_sector_base(i_cfg_sector_base), .i_cfg_sector_count(i_cfg_sector_count),
    .o_rstart(o_rstart), .o_rsector(o_rsector), .i_rbusy(i_rbusy), .i_rdone(i_rdone),
    .i_rd_data(i_rd_data), .i_rd_data_en(i_rd_data_en), .o_m_valid(o_m_valid),
    .i_m_ready(i_m_ready), .o_m_data(o_m_data), .o_m_last(o_m_last), .o_busy(o_busy),
    .o_done(o_done), .o_err_overflow(o_err_overflow), .o_err_short(o_err_short),
    .o_fifo_level(o_fifo_level)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, want);
    end
  endtask
  // sector reader model: accepts rstart, returns SW (or SW-1) random words with gaps, then rdone
  initial forever begin : rd_model
    int n;
    bit same;
    @(negedge clk);
    if (rst_n && o_rstart && !i_rbusy) begin
      sec_q.push_back(o_rsector);
      n = short_once ? SW - 1 : SW;
      short_once = 1'b0;
      same = 1'($urandom_range(0, 1));
      rd_busy = 1'b1;
      @(negedge clk);
      for (int k = 0; k < n; k++) begin
        i_rd_data = 16'($urandom);
        i_rd_data_en = 1'b1;
        if (model_en) exp_q.push_back({i_rd_data[7:0], i_rd_data[15:8]});
        if (same && k == n - 1) i_rdone = 1'b1;
        @(negedge clk);
        i_rd_data_en = 1'b0;
        i_rdone = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
      if (!same) begin
        i_rdone = 1'b1;
        @(negedge clk);
        i_rdone = 1'b0;
      end
      rd_busy = 1'b0;
    end
  end
  // consumer-side scoreboard
  always @(negedge clk) begin
    if (rst_n && o_done) done_cnt++;
    if (rst_n && o_m_valid && i_m_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
      else begin
        chk("m_data", {16'd0, o_m_data}, {16'd0, exp_q.pop_front()});
        chk("m_last", {31'd0, o_m_last}, {31'd0, pop_idx == run_words - 1});
      end
      if (o_m_last) last_cnt++;
      pop_idx++;
    end
  end
  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 i_m_ready = v;
  endtask
  task automatic start_run(input logic [31:0] base, input logic [31:0] cnt);
    @(negedge clk);
    i_cfg_sector_base = base;
    i_cfg_sector_count = cnt;
    i_cfg_start = 1'b1;
    pop_idx = 0;
    run_words = cnt * SW;
    model_en = 1'b1;
    sec_q.delete();
    @(negedge clk);
    i_cfg_start = 1'b0;
  endtask
  task automatic wait_done(input int budget, input string tag);
    int d0 = done_cnt;
    int t = 0;
    while (done_cnt == d0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(tag, {31'd0, done_cnt != d0}, 32'd1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int d0, l0, rs, t;
    repeat (3) @(negedge clk);
    chk("rst_rstart", {31'd0, o_rstart}, 32'd0);
    chk("rst_rsector", o_rsector, 32'd0);
    chk("rst_flags", {26'd0, o_m_valid, o_m_last, o_busy, o_done, o_err_overflow, o_err_short}, 32'd0);
    chk("rst_level_data", {o_fifo_level, o_m_data}, 32'd0);
    rst_n = 1'b1;
    // 1: basic three-sector run
    d0 = done_cnt; l0 = last_cnt;
    set_ready(1'b1);
    start_run(32'd100, 32'd3);
    wait_done(5000, "t1_done");
    chk("t1_nsec", sec_q.size(), 32'd3);
    if (sec_q.size() == 3) for (int i = 0; i < 3; i++) chk("t1_rsector", sec_q[i], 32'd100 + i);
    chk("t1_words", pop_idx, 32'd768);
    chk("t1_last", last_cnt - l0, 32'd1);
    chk("t1_errs", {30'd0, o_err_overflow, o_err_short}, 32'd0);
    repeat (5) @(negedge clk);
    chk("t1_done_once", done_cnt - d0, 32'd1);
    chk("t1_idle", {31'd0, o_busy}, 32'd0);
    // 2: stalled consumer throttles requests
    set_ready(1'b0);
    start_run(32'd200, 32'd4);
    t = 0;
    while (o_fifo_level != 10'd512 && t < 3000) begin @(negedge clk); t++; end
    rs = 0;
    repeat (100) begin @(negedge clk); if (o_rstart) rs++; end
    chk("t2_level", {22'd0, o_fifo_level}, 32'd512);
    chk("t2_nsec", sec_q.size(), 32'd2);
    chk("t2_no_rstart", rs, 32'd0);
    chk("t2_busy", {31'd0, o_busy}, 32'd1);
    set_ready(1'b1);
    wait_done(5000, "t2_done");
    chk("t2_nsec_all", sec_q.size(), 32'd4);
    if (sec_q.size() == 4) chk("t2_rsector3", sec_q[3], 32'd203);
    chk("t2_words", pop_idx, 32'd1024);
    chk("t2_ovf", {31'd0, o_err_overflow}, 32'd0);
    // 3: short sector
    l0 = last_cnt;
    short_once = 1'b1;
    start_run(32'd300, 32'd2);
    wait_done(5000, "t3_done");
    chk("t3_short", {31'd0, o_err_short}, 32'd1);
    chk("t3_words", pop_idx, 32'd511);
    chk("t3_no_last", last_cnt - l0, 32'd0);
    // 5a: zero-count run
    rs = 0;
    start_run(32'd350, 32'd0);
    chk("t5_done_next", {31'd0, o_done}, 32'd1);
    chk("t5_short_clr", {31'd0, o_err_short}, 32'd0);
    @(negedge clk);
    chk("t5_done_pulse", {31'd0, o_done}, 32'd0);
    repeat (20) begin @(negedge clk); if (o_rstart) rs++; end
    chk("t5_no_rstart", rs + sec_q.size(), 32'd0);
    // 5b: reader busy holds off request
    hold_busy = 1'b1;
    start_run(32'd400, 32'd1);
    rs = 0;
    repeat (50) begin @(negedge clk); if (o_rstart && i_rbusy) rs++; end
    chk("t5_hold_nsec", sec_q.size(), 32'd0);
    chk("t5_hold_busy", {31'd0, o_busy}, 32'd1);
    hold_busy = 1'b0;
    wait_done(3000, "t5_hold_done");
    chk("t5_hold_rsector", sec_q.size() == 1 ? sec_q[0] : 32'hdead, 32'd400);
    // 4: abort mid-sector, with a simultaneous start that must lose
    d0 = done_cnt;
    set_ready(1'b0);
    start_run(32'd500, 32'd2);
    t = 0;
    while (exp_q.size() < 100 && t < 3000) begin @(negedge clk); t++; end
    @(negedge clk);
    #2;
    i_cfg_abort = 1'b1;
    i_cfg_start = 1'b1;
    model_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #2;
    i_cfg_abort = 1'b0;
    i_cfg_start = 1'b0;
    chk("t4_abort_idle", {29'd0, o_busy, o_rstart, o_m_valid}, 32'd0);
    chk("t4_abort_level", {22'd0, o_fifo_level}, 32'd0);
    t = 0;
    while (rd_busy && t < 1000) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    chk("t4_dropped", {22'd0, o_fifo_level}, 32'd0);
    chk("t4_no_done", done_cnt - d0, 32'd0);
    chk("t4_no_short", {31'd0, o_err_short}, 32'd0);
    l0 = last_cnt;
    set_ready(1'b1);
    start_run(32'd600, 32'd2);
    wait_done(5000, "t4_rerun_done");
    chk("t4_rerun_words", pop_idx, 32'd512);
    chk("t4_rerun_last", last_cnt - l0, 32'd1);
    chk("t4_rerun_sec", sec_q.size() == 2 ? sec_q[1] : 32'hdead, 32'd601);
    // 6: random consumer near full, sector number wrap
    l0 = last_cnt;
    d0 = done_cnt;
    set_ready(1'b0);
    start_run(32'hFFFF_FFFE, 32'd4);
    t = 0;
    while (o_fifo_level < 10'd500 && t < 3000) begin @(negedge clk); t++; end
    t = 0;
    while (done_cnt == d0 && t < 8000) begin
      @(posedge clk);
      #1 i_m_ready = 1'($urandom_range(0, 1));
      t++;
    end
    chk("t6_done", done_cnt - d0, 32'd1);
    chk("t6_ovf", {31'd0, o_err_overflow}, 32'd0);
    chk("t6_words", pop_idx, 32'd1024);
    chk("t6_last", last_cnt - l0, 32'd1);
    chk("t6_nsec", sec_q.size(), 32'd4);
    if (sec_q.size() == 4) begin
      chk("t6_sec1", sec_q[1], 32'hFFFF_FFFF);
      chk("t6_sec2", sec_q[2], 32'd0);
      chk("t6_sec3", sec_q[3], 32'd1);
    end
    chk("t6_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
